key_debounce_scan: RTL and testbench
====================================

Name: key_debounce_scan

Overview:
- Input-side counterpart to the LED output drivers: samples KEY_NUM asynchronous push-button pins, synchronizes them, debounces them and produces clean level and event signals.
- Event outputs are one-cycle pulses: press, release and long-press. They feed en_i-style controls of the LED blocks and other user-interface logic.
- Each key has an independent state machine and counter; all keys share one clock.

Parameters:
- KEY_NUM, 4: number of keys (1..32).
- KEY_PRESS_MODE, 1'b0: 1'b0 = pin LOW means pressed; 1'b1 = pin HIGH means pressed.
- CLK_FREQ, 50_000_000: clock frequency in Hz.
- DEBOUNCE_TIME, 20: debounce window in ms. DB_CNT_MAX = CLK_FREQ/1000*DEBOUNCE_TIME.
- LONG_PRESS_TIME, 1000: hold time for a long-press event in ms. LONG_CNT_MAX = CLK_FREQ/1000*LONG_PRESS_TIME.
- REPEAT_PERIOD, 200: auto-repeat interval in ms (used only with KEY_REPEAT_EN). RPT_CNT_MAX = CLK_FREQ/1000*REPEAT_PERIOD.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- key_i  input  KEY_NUM  raw asynchronous key pins.
- key_state_o  output  KEY_NUM  debounced level per key; 1 = pressed, independent of KEY_PRESS_MODE.
- press_o  output  KEY_NUM  one-cycle pulse on debounced press.
- release_o  output  KEY_NUM  one-cycle pulse on debounced release.
- long_o  output  KEY_NUM  one-cycle pulse when the hold reaches LONG_CNT_MAX (also carries repeat pulses, see Optional Feature).

Behaviour:
- Reset: reset is synchronous and active-low, sampled on the rising edge of clk. On reset all outputs are 0, all FSMs go to IDLE, all counters are 0, and synchronizer flops load the released level (~KEY_PRESS_MODE per bit).
- Input path:
  - 2-flop synchronizer per bit, then normalization lvl = sync ^ ~KEY_PRESS_MODE, so lvl = 1 means pressed.
  - Latency from pin to lvl: 2 cycles.
- Per-key FSM, 32-bit counter cnt:
  - IDLE: cnt = 0. lvl = 1 -> PRESS_DB.
  - PRESS_DB: cnt increments each cycle lvl = 1. lvl = 0 -> IDLE, cnt cleared, no pulse. At cnt == DB_CNT_MAX-1 with lvl = 1 -> HELD, cnt cleared, press_o pulses.
  - HELD: cnt increments each cycle. At cnt == LONG_CNT_MAX-1 -> LONG, cnt cleared, long_o pulses. lvl = 0 -> REL_DB, cnt cleared.
  - LONG: cnt holds at 0 (without KEY_REPEAT_EN). lvl = 0 -> REL_DB, cnt cleared.
  - REL_DB: cnt increments each cycle lvl = 0. lvl = 1 -> bounce back to HELD with cnt cleared if long_o had not fired this press, else to LONG; no press_o. At cnt == DB_CNT_MAX-1 with lvl = 0 -> IDLE, release_o pulses.
- Output timing:
  - All outputs are registered. Each pulse is high in the cycle after the transition that causes it.
  - key_state_o is 1 from that same cycle as press_o until the cycle carrying release_o, exclusive.
  - key_state_o stays 1 through REL_DB.
- Boundary conditions:
  - A bounce shorter than DB_CNT_MAX cycles produces no event.
  - Glitches during HELD or LONG shorter than the debounce window produce no event and no second press_o.
  - Each press produces exactly one press_o and exactly one release_o.
  - long_o fires at most once per press without KEY_REPEAT_EN.
  - Keys are fully independent; simultaneous events on different bits are all reported in the same cycle.
  - press_o and release_o are never high together for the same bit.
- Parameter rules:
  - DB_CNT_MAX >= 2 and LONG_CNT_MAX > DB_CNT_MAX; otherwise elaboration fails via a generate-time check.
  - Counter arithmetic is unsigned 32-bit and never wraps, because every state clears cnt on its terminal value.
- Reset mid-press returns the key to IDLE with no pulse. A key held through reset release is re-debounced and reported as a new press.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- When defined:
  - In LONG, cnt increments each cycle while lvl = 1.
  - At cnt == RPT_CNT_MAX-1, long_o pulses again and cnt clears, repeating until release.
  - RPT_CNT_MAX >= 2 is required.
- When undefined: no repeat logic or counter compare is generated, REPEAT_PERIOD is ignored, and long_o fires at most once per press.

Test Plan (CLK_FREQ=1000, DEBOUNCE_TIME=4, LONG_PRESS_TIME=20, REPEAT_PERIOD=5, KEY_NUM=2, KEY_PRESS_MODE=0):
- Drive key_i[0] low and hold -> press_o[0] pulses once, 2+4+1 = 7 cycles after the edge; key_state_o[0] = 1 from that cycle.
- Pulse key_i[0] low for 3 cycles, then high -> no press_o, and key_state_o[0] stays 0.
- After press, toggle key_i[0] high for 2 cycles then low -> no release_o and no second press_o; a later 4+ cycle high gives exactly one release_o[0].
- Hold key_i[1] low for 40 cycles -> press_o[1] once, then long_o[1] once, 20 cycles after press_o. With KEY_REPEAT_EN, further long_o[1] pulses every 5 cycles until release.
- Press both keys in the same cycle -> press_o = 2'b11 in one cycle; release both together -> release_o = 2'b11.
- Assert rst_n = 0 for one cycle while key_i[0] is held low in HELD -> all outputs 0 next cycle; after reset, press_o[0] fires again 7 cycles later.

Source files
------------

// File: rtl/key_debounce_scan_if.sv
// Key pins in, debounced level and one-cycle event pulses out, one bit per key.
// The design drives through the slave modport; the stimulus side uses master.
interface key_debounce_scan_if #(
  parameter int KEY_NUM = 4
);
  logic [KEY_NUM-1:0] key_i;
  logic [KEY_NUM-1:0] key_state_o;
  logic [KEY_NUM-1:0] press_o;
  logic [KEY_NUM-1:0] release_o;
  logic [KEY_NUM-1:0] long_o;

  modport master (
    output key_i,
    input  key_state_o, press_o, release_o, long_o
  );

  modport slave (
    input  key_i,
    output key_state_o, press_o, release_o, long_o
  );
endinterface

// File: rtl/key_debounce_scan.sv
// Per-key sync + debounce FSM: press/release/long pulses 1 cycle after the causing transition,
// pin to press_o = 2 + DB_CNT_MAX + 1 cycles. Define KEY_REPEAT_EN for auto-repeat on long_o.
module key_debounce_scan #(
  parameter int   KEY_NUM         = 4,
  parameter logic KEY_PRESS_MODE  = 1'b0,
  parameter int   CLK_FREQ        = 50_000_000,
  parameter int   DEBOUNCE_TIME   = 20,
  parameter int   LONG_PRESS_TIME = 1000,
  parameter int   REPEAT_PERIOD   = 200
) (
  input  logic                   clk,
  input  logic                   rst_n,
  key_debounce_scan_if.slave     bus
);

  localparam int unsigned DB_CNT_MAX   = (CLK_FREQ / 1000) * DEBOUNCE_TIME;
  localparam int unsigned LONG_CNT_MAX = (CLK_FREQ / 1000) * LONG_PRESS_TIME;
  localparam logic [31:0] DB_LAST      = 32'(DB_CNT_MAX - 1);
  localparam logic [31:0] LONG_LAST    = 32'(LONG_CNT_MAX - 1);
  localparam logic [KEY_NUM-1:0] RELEASED = {KEY_NUM{~KEY_PRESS_MODE}};

  if (KEY_NUM < 1 || KEY_NUM > 32 || CLK_FREQ < 1000 || REPEAT_PERIOD < 0) begin : g_bad_cfg
    $error("key_debounce_scan: invalid KEY_NUM/CLK_FREQ/REPEAT_PERIOD");
  end
  if (DB_CNT_MAX < 2 || LONG_CNT_MAX <= DB_CNT_MAX) begin : g_bad_cnt
    $error("key_debounce_scan: need DB_CNT_MAX >= 2 and LONG_CNT_MAX > DB_CNT_MAX");
  end

`ifdef KEY_REPEAT_EN
  localparam int unsigned RPT_CNT_MAX = (CLK_FREQ / 1000) * REPEAT_PERIOD;
  localparam logic [31:0] RPT_LAST    = 32'(RPT_CNT_MAX - 1);
  if (RPT_CNT_MAX < 2) begin : g_bad_rpt
    $error("key_debounce_scan: need RPT_CNT_MAX >= 2");
  end
`endif

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    HELD,
    LONG,
    REL_DB
  } key_fsm_t;

  logic [KEY_NUM-1:0] sync1, sync2, lvl;
  logic [KEY_NUM-1:0] state_q, press_q, release_q, long_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= RELEASED;
      sync2 <= RELEASED;
    end else begin
      sync1 <= bus.key_i;
      sync2 <= sync1;
    end
  end

  // lvl = 1 means pressed regardless of pin polarity
  assign lvl = sync2 ^ RELEASED;

  for (genvar k = 0; k < KEY_NUM; k++) begin : g_key
    key_fsm_t    st, st_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic        long_seen, long_seen_nxt;
    logic        state_r, press_r, release_r, long_r;
    logic        state_nxt, press_nxt, release_nxt, long_nxt;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        st        <= IDLE;
        cnt       <= '0;
        long_seen <= 1'b0;
        state_r   <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
        long_r    <= 1'b0;
      end else begin
        st        <= st_nxt;
        cnt       <= cnt_nxt;
        long_seen <= long_seen_nxt;
        state_r   <= state_nxt;
        press_r   <= press_nxt;
        release_r <= release_nxt;
        long_r    <= long_nxt;
      end
    end

    always_comb begin
      st_nxt        = st;
      cnt_nxt       = cnt;
      long_seen_nxt = long_seen;
      press_nxt     = 1'b0;
      release_nxt   = 1'b0;
      long_nxt      = 1'b0;
      case (st)
        IDLE: begin
          cnt_nxt       = '0;
          long_seen_nxt = 1'b0;
          if (lvl[k]) st_nxt = PRESS_DB;
        end
        PRESS_DB: begin
          if (!lvl[k]) begin
            st_nxt  = IDLE;
            cnt_nxt = '0;
          end else if (cnt == DB_LAST) begin
            st_nxt    = HELD;
            cnt_nxt   = '0;
            press_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 32'd1;
          end
        end
        HELD: begin
          if (!lvl[k]) begin
            st_nxt  = REL_DB;
            cnt_nxt = '0;
          end else if (cnt == LONG_LAST) begin
            st_nxt        = LONG;
            cnt_nxt       = '0;
            long_nxt      = 1'b1;
            long_seen_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 32'd1;
          end
        end
        LONG: begin
          if (!lvl[k]) begin
            st_nxt  = REL_DB;
            cnt_nxt = '0;
          end else begin
`ifdef KEY_REPEAT_EN
            if (cnt == RPT_LAST) begin
              cnt_nxt  = '0;
              long_nxt = 1'b1;
            end else begin
              cnt_nxt = cnt + 32'd1;
            end
`else
            cnt_nxt = '0;
`endif
          end
        end
        REL_DB: begin
          // a bounce back resumes the hold without a second press
          if (lvl[k]) begin
            st_nxt  = long_seen ? LONG : HELD;
            cnt_nxt = '0;
          end else if (cnt == DB_LAST) begin
            st_nxt      = IDLE;
            cnt_nxt     = '0;
            release_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 32'd1;
          end
        end
        default: begin
          st_nxt  = IDLE;
          cnt_nxt = '0;
        end
      endcase
      state_nxt = (st_nxt == HELD) || (st_nxt == LONG) || (st_nxt == REL_DB);
    end

    assign state_q[k]   = state_r;
    assign press_q[k]   = press_r;
    assign release_q[k] = release_r;
    assign long_q[k]    = long_r;
  end

  assign bus.key_state_o = state_q;
  assign bus.press_o     = press_q;
  assign bus.release_o   = release_q;
  assign bus.long_o      = long_q;

endmodule

// File: tb/tb_key_debounce_scan.sv
// Directed bench for key_debounce_scan with a 4-cycle debounce and 20-cycle long press.
// Expected timings are hand-derived: pin edge to pulse is 2 sync + 1 + 4 = 7 cycles.
module tb_key_debounce_scan;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   press_cnt [2];
  int   release_cnt [2];
  int   long_cnt [2];
  int   overlap_cnt = 0;

  key_debounce_scan_if #(.KEY_NUM(2)) kif ();

  key_debounce_scan #(
    .KEY_NUM        (2),
    .KEY_PRESS_MODE (1'b0),
    .CLK_FREQ       (1000),
    .DEBOUNCE_TIME  (4),
    .LONG_PRESS_TIME(20),
    .REPEAT_PERIOD  (5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (kif.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // pulse counters sampled well after each edge
  always @(posedge clk) begin
    #2;
    for (int b = 0; b < 2; b++) begin
      if (kif.press_o[b])   press_cnt[b]++;
      if (kif.release_o[b]) release_cnt[b]++;
      if (kif.long_o[b])    long_cnt[b]++;
      if (kif.press_o[b] && kif.release_o[b]) overlap_cnt++;
    end
  end

  initial begin
    for (int b = 0; b < 2; b++) begin
      press_cnt[b] = 0;
      release_cnt[b] = 0;
      long_cnt[b] = 0;
    end
    rst_n = 1'b0;
    kif.key_i = 2'b11;
    tick(3);
    check("rst_state", 32'(kif.key_state_o), 32'h0);
    check("rst_press", 32'(kif.press_o), 32'h0);
    check("rst_release", 32'(kif.release_o), 32'h0);
    check("rst_long", 32'(kif.long_o), 32'h0);
    rst_n = 1'b1;
    tick(2);

    // clean press on key 0
    kif.key_i[0] = 1'b0;
    tick(6);
    check("press0_early", 32'(kif.press_o), 32'h0);
    tick(1);
    check("press0_pulse", 32'(kif.press_o), 32'h1);
    check("press0_state", 32'(kif.key_state_o), 32'h1);
    tick(1);
    check("press0_one_cycle", 32'(kif.press_o), 32'h0);

    // 2-cycle release glitch while held
    kif.key_i[0] = 1'b1;
    tick(2);
    kif.key_i[0] = 1'b0;
    tick(10);
    check("glitch_press_cnt", 32'(press_cnt[0]), 32'd1);
    check("glitch_rel_cnt", 32'(release_cnt[0]), 32'd0);
    check("glitch_state", 32'(kif.key_state_o), 32'h1);

    kif.key_i[0] = 1'b1;
    tick(6);
    check("rel0_early", 32'(kif.release_o), 32'h0);
    check("rel0_state_held", 32'(kif.key_state_o), 32'h1);
    tick(1);
    check("rel0_pulse", 32'(kif.release_o), 32'h1);
    check("rel0_state", 32'(kif.key_state_o), 32'h0);
    check("rel0_no_long", 32'(long_cnt[0]), 32'd0);
    tick(5);

    // 3-cycle bounce: no event
    kif.key_i[0] = 1'b0;
    tick(3);
    kif.key_i[0] = 1'b1;
    tick(10);
    check("bounce_press_cnt", 32'(press_cnt[0]), 32'd1);
    check("bounce_state", 32'(kif.key_state_o), 32'h0);

    // long press on key 1, 40 cycles
    kif.key_i[1] = 1'b0;
    tick(7);
    check("press1_pulse", 32'(kif.press_o), 32'h2);
    tick(19);
    check("long1_early", 32'(kif.long_o), 32'h0);
    tick(1);
    check("long1_pulse", 32'(kif.long_o), 32'h2);
`ifdef KEY_REPEAT_EN
    tick(4);
    check("rpt1_early", 32'(kif.long_o), 32'h0);
    tick(1);
    check("rpt1_pulse", 32'(kif.long_o), 32'h2);
    tick(8);
`else
    tick(13);
`endif
    kif.key_i[1] = 1'b1;
    tick(7);
    check("rel1_pulse", 32'(kif.release_o), 32'h2);
`ifdef KEY_REPEAT_EN
    check("long1_cnt", 32'(long_cnt[1]), 32'd4);
`else
    check("long1_cnt", 32'(long_cnt[1]), 32'd1);
`endif
    check("press1_cnt", 32'(press_cnt[1]), 32'd1);
    tick(5);

    // simultaneous press and release on both keys
    kif.key_i = 2'b00;
    tick(7);
    check("both_press", 32'(kif.press_o), 32'h3);
    check("both_state", 32'(kif.key_state_o), 32'h3);
    tick(5);
    kif.key_i = 2'b11;
    tick(7);
    check("both_release", 32'(kif.release_o), 32'h3);
    check("both_state_off", 32'(kif.key_state_o), 32'h0);
    tick(5);

    // reset while key 0 is held
    kif.key_i[0] = 1'b0;
    tick(10);
    check("pre_rst_state", 32'(kif.key_state_o), 32'h1);
    rst_n = 1'b0;
    tick(1);
    check("mid_rst_state", 32'(kif.key_state_o), 32'h0);
    check("mid_rst_pulses", 32'({kif.press_o, kif.release_o, kif.long_o}), 32'h0);
    rst_n = 1'b1;
    tick(6);
    check("repress_early", 32'(kif.press_o), 32'h0);
    tick(1);
    check("repress_pulse", 32'(kif.press_o), 32'h1);
    kif.key_i[0] = 1'b1;
    tick(7);
    check("final_release", 32'(kif.release_o), 32'h1);
    tick(3);

    check("press0_total", 32'(press_cnt[0]), 32'd4);
    check("release0_total", 32'(release_cnt[0]), 32'd3);
    check("press1_total", 32'(press_cnt[1]), 32'd2);
    check("release1_total", 32'(release_cnt[1]), 32'd2);
    check("press_rel_overlap", 32'(overlap_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
